// File: rtl/register_dump_reader.sv
// register_dump_reader: walks a 4-entry register bank under a bit mask and
// streams the selected bytes over a valid/ready interface, optionally
// followed by an XOR checksum byte.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; mask latched on acceptance
// FETCH | rd_reg=idx; capture selected byte or skip unselected register
// SEND  | present captured byte until the sink takes it
// CSUM  | present XOR of all sent bytes as the final byte
// DONE  | one-cycle completion pulse, back to IDLE
module register_dump_reader #(
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  output logic [1:0] rd_reg,
  input  logic [7:0] rd_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, DONE} state_t;

  state_t     state, state_d, tail_state;
  logic [1:0] idx, idx_d;
  logic [3:0] mask_q, mask_d;
  logic [7:0] csum, csum_d;
  logic [7:0] data_q, data_d;
  logic [3:0] shifted;
  logic       upper_set;

  // State and datapath registers; reset abandons any dump immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 2'd0;
      mask_q <= 4'd0;
      csum   <= 8'h00;
      data_q <= 8'h00;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      mask_q <= mask_d;
      csum   <= csum_d;
      data_q <= data_d;
    end
  end

  // Next-state, datapath updates and stream handshake outputs.
  // out_data is always data_q; data_q is loaded with the checksum when the
  // FSM heads into CSUM so the output never has to be muxed.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    mask_d     = mask_q;
    csum_d     = csum;
    data_d     = data_q;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    shifted    = mask_q >> idx;
    upper_set  = |shifted[3:1];
    tail_state = CHECKSUM_EN ? CSUM : DONE;

    case (state)
      IDLE: begin
        if (start) begin
          mask_d  = mask;
          idx_d   = 2'd0;
          csum_d  = 8'h00;
          data_d  = 8'h00;
          state_d = (mask == 4'd0) ? tail_state : FETCH;
        end
      end
      FETCH: begin
        if (mask_q[idx]) begin
          data_d  = rd_data;
          state_d = SEND;
        end else if (idx == 2'd3) begin
          data_d  = csum;
          state_d = tail_state;
        end else begin
          idx_d = idx + 2'd1;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = !CHECKSUM_EN && !upper_set;
        if (out_ready) begin
          csum_d = csum ^ data_q;
          if (!upper_set) begin
            data_d  = csum ^ data_q;
            state_d = tail_state;
          end else begin
            idx_d   = idx + 2'd1;
            state_d = FETCH;
          end
        end
      end
      CSUM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        if (out_ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_reg   = idx;
  assign out_data = data_q;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule
